// File: rtl/zbt_point_loader.sv
// Purpose: writes the point table into ZBT SRAM on start, then hands the port to the renderer's reads.
// Latency: write data on the bus ZBT_LAT cycles after its address; rd_valid/rd_data ZBT_LAT cycles after rd_ack.
// Backpressure: rd_ack is 0 while loading or while a start is held, and the requester keeps rd_req up until it sees rd_ack.
// Optional readback check: define ZBT_VERIFY_EN to re-read and compare the table after each load.
// Read timing: zbt_rdata must carry the word for the address issued in cycle t by cycle t+ZBT_LAT-1.
// rd_data registers that word, and it appears together with rd_valid in cycle t+ZBT_LAT.
module zbt_point_loader #(
    parameter int          NUM_POINTS = 31,
    parameter logic [18:0] BASE_ADDR  = 19'h00000,
    parameter int          ZBT_LAT    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [8:0]  point_index,
    input  logic [35:0] point_value,
    input  logic        rd_req,
    input  logic [18:0] rd_addr,
    output logic        rd_ack,
    output logic [35:0] rd_data,
    output logic        rd_valid,
    output logic [18:0] zbt_addr,
    output logic        zbt_we_b,
    output logic [35:0] zbt_wdata,
    output logic        zbt_oe,
    input  logic [35:0] zbt_rdata,
    output logic        busy,
    output logic        done,
    output logic        verify_err
);

    localparam logic [8:0] LAST_IDX = 9'(NUM_POINTS - 1);
    localparam logic [7:0] LAST_CNT = 8'(ZBT_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
`ifdef ZBT_VERIFY_EN
        S_VERIFY,
        S_VWAIT,
`endif
        S_DONE,
        S_SERVE
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [8:0]  idx;
    logic [7:0]  cnt;
    logic        start_pend;
    logic        serving;
    logic        outstanding;
    logic        load_go;
    logic        capture_en;
    logic        rd_tap;

    // data pipeline: stage 1 takes the table word, stage ZBT_LAT drives the bus
    logic [35:0]      pdat [1:ZBT_LAT];
    logic [ZBT_LAT:1] wr_pipe;
    logic [ZBT_LAT:1] rv_pipe;

    assign point_index = idx;
    assign zbt_wdata   = pdat[ZBT_LAT];
    assign zbt_oe      = wr_pipe[ZBT_LAT];
    assign rd_valid    = rv_pipe[ZBT_LAT];
    assign serving     = (state == S_IDLE) || (state == S_SERVE);
    // a start (fresh or held) launches the load only once no renderer read is still in flight
    assign load_go     = serving && (start || start_pend) && !outstanding;

`ifdef ZBT_VERIFY_EN
    assign capture_en = (state == S_LOAD) || (state == S_VERIFY);
`else
    assign capture_en = (state == S_LOAD);
`endif

    // a read is in flight while its ack bit sits in any stage before rd_valid
    always_comb begin
        outstanding = 1'b0;
        for (int k = 1; k < ZBT_LAT; k++) begin
            outstanding = outstanding | rv_pipe[k];
        end
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_SERVE: if (load_go) next_state = S_LOAD;
            S_LOAD:          if (idx == LAST_IDX) next_state = S_DRAIN;
`ifdef ZBT_VERIFY_EN
            S_DRAIN:         if (cnt == LAST_CNT) next_state = S_VERIFY;
            S_VERIFY:        if (idx == LAST_IDX) next_state = S_VWAIT;
            S_VWAIT:         if (cnt == LAST_CNT) next_state = S_DONE;
`else
            S_DRAIN:         if (cnt == LAST_CNT) next_state = S_DONE;
`endif
            S_DONE:          next_state = S_SERVE;
            default:         next_state = S_IDLE;
        endcase
    end

    // output decode: port ownership, write strobe and status
    always_comb begin
        zbt_we_b = 1'b1;
        zbt_addr = '0;
        rd_ack   = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            S_IDLE, S_SERVE: begin
                if (rd_req && !start && !start_pend) begin
                    rd_ack   = 1'b1;
                    zbt_addr = rd_addr;
                end
            end
            S_LOAD: begin
                zbt_we_b = 1'b0;
                zbt_addr = BASE_ADDR + {10'd0, idx};
                busy     = 1'b1;
            end
            S_DRAIN: busy = 1'b1;
`ifdef ZBT_VERIFY_EN
            S_VERIFY: begin
                zbt_addr = BASE_ADDR + {10'd0, idx};
                busy     = 1'b1;
            end
            S_VWAIT: busy = 1'b1;
`endif
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // table index, drain counter and held start request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= '0;
            cnt        <= '0;
            start_pend <= 1'b0;
        end else begin
            if (next_state != state) begin
                cnt <= '0;
            end else if (state != S_IDLE && state != S_SERVE) begin
                cnt <= cnt + 8'd1;
            end

            if (load_go) begin
                idx <= '0;
`ifdef ZBT_VERIFY_EN
            end else if (state == S_DRAIN && next_state == S_VERIFY) begin
                idx <= '0;
`endif
            end else if (capture_en && idx != LAST_IDX) begin
                idx <= idx + 9'd1;
            end

            if (load_go) begin
                start_pend <= 1'b0;
            end else if (serving && start) begin
                start_pend <= 1'b1;
            end
        end
    end

    // write-data and read-ack delay lines; reset flushes anything still headed for the bus
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k <= ZBT_LAT; k++) begin
                pdat[k] <= '0;
            end
            wr_pipe <= '0;
            rv_pipe <= '0;
        end else begin
            pdat[1]    <= capture_en ? point_value : 36'd0;
            wr_pipe[1] <= (state == S_LOAD);
            rv_pipe[1] <= rd_ack;
            for (int k = 2; k <= ZBT_LAT; k++) begin
                pdat[k]    <= pdat[k-1];
                wr_pipe[k] <= wr_pipe[k-1];
                rv_pipe[k] <= rv_pipe[k-1];
            end
        end
    end

`ifdef ZBT_VERIFY_EN
    logic [ZBT_LAT:1] chk_pipe;
    logic             cmp_chk;
    logic [35:0]      cmp_dat;
`endif

    // tap of the delay lines one stage before the end, where returning read words are captured
    generate
        if (ZBT_LAT == 1) begin : g_tap_first
            assign rd_tap = rd_ack;
`ifdef ZBT_VERIFY_EN
            assign cmp_chk = (state == S_VERIFY);
            assign cmp_dat = point_value;
`endif
        end else begin : g_tap_pipe
            assign rd_tap = rv_pipe[ZBT_LAT-1];
`ifdef ZBT_VERIFY_EN
            assign cmp_chk = chk_pipe[ZBT_LAT-1];
            assign cmp_dat = pdat[ZBT_LAT-1];
`endif
        end
    endgenerate

    // capture returned read data for the renderer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_tap) begin
            rd_data <= zbt_rdata;
        end
    end

`ifdef ZBT_VERIFY_EN
    // readback marker travels alongside the expected word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_pipe <= '0;
        end else begin
            chk_pipe[1] <= (state == S_VERIFY);
            for (int k = 2; k <= ZBT_LAT; k++) begin
                chk_pipe[k] <= chk_pipe[k-1];
            end
        end
    end

    // sticky mismatch flag, cleared when a new load begins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            verify_err <= 1'b0;
        end else if (load_go) begin
            verify_err <= 1'b0;
        end else if (cmp_chk && (zbt_rdata != cmp_dat)) begin
            verify_err <= 1'b1;
        end
    end
`else
    assign verify_err = 1'b0;
`endif

endmodule

// File: doc/zbt_point_loader.md
Name: zbt_point_loader

Overview:
- Sequences the 3D point table (36-bit words {6'b0, x[9:0], y[9:0], z[9:0]}, signed 10-bit axes) into ZBT SRAM after power-up or on command.
- Then shares the single ZBT port with the renderer's read requester.
- Sits between the point-table lookup, the ZBT pins and the projection/render pipeline.
- Owns all ZBT address, write-enable and data-bus control.

Parameters:
- NUM_POINTS, 31, number of table entries loaded; indices 0..NUM_POINTS-1; range 1..512.
- BASE_ADDR, 19'h00000, ZBT word address where entry 0 is written.
- ZBT_LAT, 2, ZBT pipeline depth; cycles from address/we to data on the bus, for both write and read.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse that requests a (re)load of the table.
- point_index  out  9  index presented to the point table.
- point_value  in  36  table word, combinationally valid in the same cycle as point_index.
- rd_req  in  1  renderer read request.
- rd_addr  in  19  renderer word address.
- rd_ack  out  1  request accepted this cycle.
- rd_data  out  36  read data.
- rd_valid  out  1  rd_data valid; 1-cycle pulse.
- zbt_addr  out  19  ZBT address.
- zbt_we_b  out  1  ZBT write enable, active-low.
- zbt_wdata  out  36  ZBT write data.
- zbt_oe  out  1  1 = drive zbt_wdata onto the bidirectional bus.
- zbt_rdata  in  36  ZBT read bus.
- busy  out  1  load in progress (states LOAD and DRAIN).
- done  out  1  1-cycle pulse when the load completes.
- verify_err  out  1  sticky readback mismatch flag (see Optional Feature).

Behaviour:
- Reset values: state=IDLE; point_index=0; zbt_addr=0; zbt_we_b=1; zbt_wdata=0; zbt_oe=0; rd_ack=0; rd_data=0; rd_valid=0; busy=0; done=0; verify_err=0. All pipeline registers are cleared.
- Reset asserted mid-operation aborts immediately. The write-data pipeline is flushed, so no further write data is driven. The entry being written may be corrupt; a new start is required.

FSM states:
- IDLE:
  - start -> LOAD with idx=0.
  - rd_req is served exactly as in SERVE, so the renderer may read before the first load.
- LOAD:
  - Each cycle: point_index=idx, zbt_addr=BASE_ADDR+idx, zbt_we_b=0. point_value enters a ZBT_LAT-deep data pipeline together with an active bit.
  - idx increments every cycle.
  - After the cycle with idx=NUM_POINTS-1 -> DRAIN.
- DRAIN:
  - zbt_we_b=1 for ZBT_LAT cycles while the last data words reach the bus.
  - Then done=1 for one cycle -> SERVE.
- SERVE:
  - Renderer owns the port.
  - rd_req=1 -> rd_ack=1 in the same cycle, zbt_addr=rd_addr, zbt_we_b=1.
  - ZBT_LAT cycles later: rd_data=zbt_rdata (registered) and rd_valid=1.
  - Back-to-back requests are accepted every cycle.

Write data timing:
- zbt_wdata/zbt_oe for the write issued in cycle t are driven in cycle t+ZBT_LAT.
- zbt_oe=0 in every cycle that carries no write data.

Boundary conditions:
- start while busy=1: ignored.
- start in SERVE/IDLE with reads outstanding (rd_valid pending): load is deferred until the read pipeline is empty. rd_ack=0 from the start cycle onward; the start is held internally.
- start and rd_req in the same cycle: start wins; rd_ack=0.
- rd_req during LOAD/DRAIN: rd_ack=0; the renderer must hold rd_req.
- point_index holds NUM_POINTS-1 after the load; it does not wrap.
- zbt_addr = BASE_ADDR+idx is computed modulo 2^19 and wraps silently.
- NUM_POINTS=1: LOAD lasts exactly 1 cycle.

Optional Feature:
- Macro: ZBT_VERIFY_EN.
- Defined:
  - After DRAIN, a VERIFY state re-reads all NUM_POINTS addresses, one per cycle, with point_index re-driven so point_value is available for comparison.
  - Each returned word is compared ZBT_LAT cycles later against the delayed point_value. Any mismatch sets verify_err.
  - verify_err is sticky until the next start or reset. busy stays 1 throughout VERIFY.
  - done fires after the last compare (total load time 2*NUM_POINTS+2*ZBT_LAT+1 cycles).
- Undefined: no VERIFY state; verify_err is tied to 0.

Test Plan:
- Reset, start at cycle 5 with NUM_POINTS=31 -> zbt_we_b=0 for cycles 6..36 with addr 0..30. Data at addr 30 is {6'b0,10'd300,-10'd100,-10'd100} on zbt_wdata at cycle 38. done pulses at cycle 39. No zbt_oe outside cycles 8..38.
- rd_req held from cycle 10 with rd_addr=13 during the load -> rd_ack first at cycle 39+1. rd_valid two cycles after rd_ack, with rd_data=36'h0 (point 13 = origin) from the ZBT model.
- Four back-to-back reads, addr 0..3, in SERVE -> four rd_ack in consecutive cycles. Four rd_valid in consecutive cycles, data matching entries 0..3 in order.
- start pulsed during LOAD, then again during SERVE with one read outstanding -> first start ignored. Second start: the reload begins only after that read's rd_valid; rd_ack=0 in between.
- rst_n low at the LOAD cycle with idx=12 -> all outputs return to reset values asynchronously. No zbt_oe for the two pipelined words. IDLE after release.
- With ZBT_VERIFY_EN and the ZBT model corrupting addr 27 -> verify_err=1 and stays 1 after done. A clean reload clears it to 0.
